// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: ROM fetch into a DEPTH-entry FIFO, head presented to the core via valid/ready.
// Latency: a fetched word is visible on o_valid one cycle after o_rom_ce; a redirect target appears two cycles after flush.
// Backpressure: fetching stops while the registered count is full; i_ready never reaches o_rom_ce. Optional stats: PREFETCH_STATS_EN.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     o_rom_ce,
    output logic [31:0]              o_rom_addr,
    input  logic [31:0]              i_rom_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [31:0]              o_inst,
    output logic [31:0]              o_pc,
    input  logic                     i_flush,
    input  logic [31:0]              i_flush_pc,
    output logic [$clog2(DEPTH):0]   o_count
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]              o_fetch_cnt,
    output logic [15:0]              o_flush_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_inst [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   fetch_pc;
    logic          rst_q;
    logic          push;
    logic          pop;

    // Fetch gating uses only registered state so the core's ready has no path to the ROM.
    assign o_rom_ce   = !rst_q && (count < CW'(DEPTH)) && !i_flush;
    assign o_rom_addr = fetch_pc;
    assign push       = o_rom_ce;
    assign o_valid    = (count != '0);
    assign pop        = o_valid && i_ready;
    assign o_inst     = o_valid ? mem_inst[rd_ptr] : '0;
    assign o_pc       = o_valid ? mem_pc[rd_ptr]   : '0;
    assign o_count    = count;

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fetch_pc <= RESET_PC;
        end else if (i_flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fetch_pc <= i_flush_pc;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                fetch_pc <= fetch_pc + 32'(PC_STEP);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_inst[wr_ptr] <= i_rom_data;
            mem_pc[wr_ptr]   <= fetch_pc;
        end
    end

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_fetch_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            if (push) begin
                o_fetch_cnt <= o_fetch_cnt + 32'd1;
            end
            if (i_flush && (o_flush_cnt != 16'hFFFF)) begin
                o_flush_cnt <= o_flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Scoreboarded bench: two queue instances (default reset PC, and a reset PC next to the 32-bit wrap).
module tb_inst_prefetch_queue;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: default parameters
    logic        rst = 1'b1;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        valid;
    logic        ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic [2:0]  count;
`ifdef PREFETCH_STATS_EN
    logic [31:0] fetch_cnt;
    logic [15:0] flush_cnt;
`endif

    // instance B: reset PC just below the address wrap
    logic        rst_b = 1'b1;
    logic        rom_ce_b;
    logic [31:0] rom_addr_b;
    logic [31:0] rom_data_b;
    logic        valid_b;
    logic        ready_b = 1'b1;
    logic [31:0] inst_b;
    logic [31:0] pc_b;
    logic [2:0]  count_b;
`ifdef PREFETCH_STATS_EN
    logic [31:0] fetch_cnt_b;
    logic [15:0] flush_cnt_b;
`endif

    int vecs  = 0;
    int fails = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_b[$];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom_word = 32'h3401_1100;
            32'h0000_0004: rom_word = 32'h3402_0020;
            default:       rom_word = {8'h24, a[23:0]};
        endcase
    endfunction

    assign rom_data   = rom_word(rom_addr);
    assign rom_data_b = rom_word(rom_addr_b);

    inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .o_rom_ce(rom_ce), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
        .o_valid(valid), .i_ready(ready), .o_inst(inst), .o_pc(pc),
        .i_flush(flush), .i_flush_pc(flush_pc), .o_count(count)
`ifdef PREFETCH_STATS_EN
        , .o_fetch_cnt(fetch_cnt), .o_flush_cnt(flush_cnt)
`endif
    );

    inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_b (
        .clk(clk), .rst(rst_b), .o_rom_ce(rom_ce_b), .o_rom_addr(rom_addr_b), .i_rom_data(rom_data_b),
        .o_valid(valid_b), .i_ready(ready_b), .o_inst(inst_b), .o_pc(pc_b),
        .i_flush(1'b0), .i_flush_pc(32'h0), .o_count(count_b)
`ifdef PREFETCH_STATS_EN
        , .o_fetch_cnt(fetch_cnt_b), .o_flush_cnt(flush_cnt_b)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst   = 1'b1;
        flush = 1'b0;
        ready = rdy;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Monitors: every accepted head (outside reset/flush) must match the next expected entry.
    always @(negedge clk) begin
        if (flush) begin
            assert (flush_pc[1:0] == 2'b00) else $error("illegal unaligned flush target %h", flush_pc);
        end
        if (!rst && !flush && valid && ready) begin
            if (exp_q.size() == 0) begin
                vecs++;
                fails++;
                $display("FAIL unexpected_pop_a: got pc %h, expected no delivery", pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("head_pc_a", pc, e[63:32]);
                chk("head_inst_a", inst, e[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && valid_b && ready_b) begin
            if (exp_b.size() == 0) begin
                vecs++;
                fails++;
                $display("FAIL unexpected_pop_b: got pc %h, expected no delivery", pc_b);
            end else begin
                logic [63:0] e;
                e = exp_b.pop_front();
                chk("head_pc_b", pc_b, e[63:32]);
                chk("head_inst_b", inst_b, e[31:0]);
            end
        end
    end

    initial begin
        // reset state
        ready = 1'b1;
        repeat (3) tick();
        #3;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ce", 32'(rom_ce), 32'd0);
        chk("rst_addr", rom_addr, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", pc, 32'h0);

        // sequential stream at full rate
        exp_q.push_back({32'h0, 32'h3401_1100});
        exp_q.push_back({32'h4, 32'h3402_0020});
        for (int i = 2; i < 8; i++) exp_q.push_back({32'(i * 4), rom_word(32'(i * 4))});
        tick();
        rst = 1'b0;
        #3;
        chk("first_cycle_ce", 32'(rom_ce), 32'd0);
        chk("first_cycle_valid", 32'(valid), 32'd0);
        tick(); #3;
        chk("second_cycle_ce", 32'(rom_ce), 32'd1);
        chk("second_cycle_addr", rom_addr, 32'h0);
        chk("second_cycle_valid", 32'(valid), 32'd0);
        tick(); #3;
        chk("third_cycle_valid", 32'(valid), 32'd1);
        chk("third_cycle_count", 32'(count), 32'd1);
        repeat (8) tick();
        ready = 1'b0;
        chk("stream_drained", exp_q.size(), 32'd0);

        // fill to full with core stalled, then drain
        do_reset(1'b0);
        repeat (7) tick();
        #3;
        chk("full_count", 32'(count), 32'd4);
        chk("full_ce", 32'(rom_ce), 32'd0);
        chk("full_addr_hold", rom_addr, 32'h10);
        chk("full_valid", 32'(valid), 32'd1);
        for (int i = 0; i < 6; i++) exp_q.push_back({32'(i * 4), rom_word(32'(i * 4))});
        tick();
        ready = 1'b1;
        repeat (6) tick();
        ready = 1'b0;
        chk("full_drained", exp_q.size(), 32'd0);

        // single flush with three entries queued
        do_reset(1'b0);
        exp_q.push_back({32'h40, rom_word(32'h40)});
        exp_q.push_back({32'h44, rom_word(32'h44)});
        repeat (4) tick();
        flush = 1'b1; flush_pc = 32'h40; ready = 1'b1;
        #3;
        chk("preflush_count", 32'(count), 32'd3);
        chk("flush_ce", 32'(rom_ce), 32'd0);
        tick();
        flush = 1'b0;
        #3;
        chk("postflush_count", 32'(count), 32'd0);
        chk("postflush_valid", 32'(valid), 32'd0);
        chk("postflush_addr", rom_addr, 32'h40);
        repeat (3) tick();
        ready = 1'b0;
        chk("flush_drained", exp_q.size(), 32'd0);

        // back-to-back flushes: the last target wins
        do_reset(1'b0);
        exp_q.push_back({32'hC0, rom_word(32'hC0)});
        exp_q.push_back({32'hC4, rom_word(32'hC4)});
        repeat (6) tick();
        flush = 1'b1; flush_pc = 32'h80; ready = 1'b1;
        tick();
        flush_pc = 32'hC0;
        tick();
        flush = 1'b0;
        #3;
        chk("b2b_addr", rom_addr, 32'hC0);
        chk("b2b_count", 32'(count), 32'd0);
        repeat (3) tick();
        ready = 1'b0;
        chk("b2b_drained", exp_q.size(), 32'd0);

        // address wrap on instance B
        exp_b.push_back({32'hFFFF_FFF8, rom_word(32'hFFFF_FFF8)});
        exp_b.push_back({32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC)});
        exp_b.push_back({32'h0000_0000, rom_word(32'h0000_0000)});
        #3;
        chk("wrap_rst_addr", rom_addr_b, 32'hFFFF_FFF8);
        tick();
        rst_b = 1'b0;
        repeat (5) tick();
        ready_b = 1'b0;
        chk("wrap_drained", exp_b.size(), 32'd0);

`ifdef PREFETCH_STATS_EN
        do_reset(1'b0);
        repeat (6) tick();
        flush = 1'b1; flush_pc = 32'h100;
        tick();
        flush = 1'b0;
        repeat (5) tick();
        flush = 1'b1; flush_pc = 32'h200;
        tick();
        flush = 1'b0;
        repeat (2) tick();
        #3;
        chk("stats_fetch_cnt", fetch_cnt, 32'd10);
        chk("stats_flush_cnt", 32'(flush_cnt), 32'd2);
        rst = 1'b1;
        tick(); #3;
        chk("stats_fetch_rst", fetch_cnt, 32'd0);
        chk("stats_flush_rst", 32'(flush_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Instruction prefetch stage between the instruction ROM and the MIPSCPU fetch port.
- Drives ROM chip-enable and address, and captures fetched words with their PCs into a small FIFO.
- Presents the oldest entry to the core through a valid/ready handshake.
- A redirect (branch/jump/exception) flush discards all queued words and restarts fetching at a new PC.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset (`RSTENABLE = 1'b1).
- o_rom_ce  output  1  ROM read enable.
- o_rom_addr  output  `INSTADDRBUS (32)  ROM byte address.
- i_rom_data  input  `INSTBUS (32)  ROM read data, combinational: valid in the same cycle as ce/addr.
- o_valid  output  1  head entry available to core.
- i_ready  input  1  core accepts head this cycle.
- o_inst  output  32  head instruction word.
- o_pc  output  32  PC of head instruction.
- i_flush  input  1  discard queue and redirect fetch.
- i_flush_pc  input  32  redirect target, word aligned.
- o_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- State: storage mem_inst[DEPTH] and mem_pc[DEPTH]; wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH; count; fetch_pc (32 bits).
- Reset (rst=1 at edge):
  - count=0, pointers=0, fetch_pc=RESET_PC.
  - o_valid=0, o_count=0, o_rom_ce=0.
  - o_rom_addr=RESET_PC; o_inst and o_pc=0 while empty.
  - rst overrides flush, push and pop.
- Fetch:
  - o_rom_ce = !rst_q && (count < DEPTH) && !i_flush, where rst_q is rst registered one cycle. No fetch is issued in the first cycle after reset deasserts.
  - o_rom_addr = fetch_pc at all times.
  - push = o_rom_ce. On push: mem[wr_ptr] <= {i_rom_data, fetch_pc}; wr_ptr++; fetch_pc += PC_STEP, wrapping modulo 2^32.
- Full: push depends on registered count only. When full, no push occurs even if a pop happens that cycle (no ready-to-ce combinational path). fetch_pc holds.
- Pop: pop = o_valid && i_ready. On pop, rd_ptr++. o_valid = (count != 0). o_inst and o_pc come from mem[rd_ptr] combinationally.
- Count update: push without pop, +1; pop without push, -1; both or neither, unchanged.
- Empty: o_valid=0; i_ready is ignored; o_inst and o_pc are don't-care.
- Flush (i_flush=1, rst=0):
  - Next edge: count=0, rd_ptr=wr_ptr=0, fetch_pc=i_flush_pc.
  - No push and no pop take effect that cycle. Flush beats a simultaneous pop; the core must treat a head accepted in the flush cycle as squashed.
  - First word from the redirect target is visible (o_valid=1, o_pc=i_flush_pc) two cycles after the flush cycle.
  - Back-to-back flushes: the last one wins.
- Latency: an empty, unstalled queue delivers a fetched word on o_valid one cycle after o_rom_ce. Steady-state throughput is one instruction per cycle.
- i_flush_pc[1:0] != 0 is illegal; the bench asserts on it and the RTL does not check it.

Optional Feature:
- Macro: PREFETCH_STATS_EN.
- Defined:
  - Adds output o_fetch_cnt[31:0], incremented on every push.
  - Adds output o_flush_cnt[15:0], incremented on every flush cycle, saturating at 16'hFFFF.
  - Both counters clear on rst and are not cleared by flush.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset release, ROM words 0x34011100, 0x34020020, ... at 0x0, 0x4, ...; i_ready=1 -> first o_valid with o_pc=0x0 and o_inst=0x34011100 two cycles after rst falls; then one instruction per cycle with PCs 0x0, 0x4, 0x8 in order.
- i_ready=0 from reset, DEPTH=4 -> exactly 4 pushes; o_count=4; o_rom_ce=0; fetch_pc holds 0x10. Raise i_ready -> PCs 0x0, 0x4, 0x8, 0xC delivered, then 0x10 follows with no gap greater than one cycle.
- Queue holds 3 entries; pulse i_flush with i_flush_pc=0x40 while i_ready=1 -> next cycle o_count=0 and o_valid=0; then o_pc=0x40, 0x44 delivered; no stale PC ever appears after the flush.
- i_flush asserted 2 consecutive cycles with targets 0x80 then 0xC0 -> first delivered PC is 0xC0.
- RESET_PC=32'hFFFF_FFF8, i_ready=1 -> delivered PCs are 0xFFFFFFF8, 0xFFFFFFFC, 0x0 (address wrap).
- With PREFETCH_STATS_EN: 10 pushes and 2 flushes -> o_fetch_cnt=10 and o_flush_cnt=2; assert rst -> both read 0.
